// File: rtl/fp_int_acc.sv
// rtl/fp_int_acc.sv - FP16xINT partial-product aligner and group accumulator
//
// Purpose: samples each finished partial product from the bit-serial
// multiplier, aligns it onto a signed fixed-point grid and sums `len`
// products per group. One result per group, one product per cycle sustained.
//
// Ports:
//   clk          clock
//   rst          synchronous active-low reset
//   set          load len, abort any group in progress
//   len          products per group (0 behaves as 1)
//   start_acc    product strobe qualifying sign_in/exp_in/mantissa_in
//   sign_in      product sign (1 = negative)
//   exp_in       FP16 biased exponent of the product (0 = zero product)
//   mantissa_in  unsigned 4.10 magnitude
//   result       signed group sum, held until the next group completes
//   result_valid one-cycle pulse when result updates
//   busy         group partially accumulated or a term in flight
//   sat          completed group saturated (qualified by result_valid)
//
// Build option: FP_INT_ACC_SAT_EN selects clamping accumulation with a
// sticky per-group sat flag; otherwise the sum wraps and sat stays 0.

module fp_int_acc #(
  parameter int ACC_WIDTH = 48,
  parameter int FRAC_BITS = 24,
  parameter int LEN_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 set,
  input  logic [LEN_WIDTH-1:0] len,
  input  logic                 start_acc,
  input  logic                 sign_in,
  input  logic [4:0]           exp_in,
  input  logic [13:0]          mantissa_in,
  output logic [ACC_WIDTH-1:0] result,
  output logic                 result_valid,
  output logic                 busy,
  output logic                 sat
);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t               state;
  logic [ACC_WIDTH-1:0] t;
  logic                 t_vld;
  logic [ACC_WIDTH-1:0] acc;
  logic [LEN_WIDTH-1:0] cnt;
  logic [LEN_WIDTH-1:0] len_q;
  logic                 sat_grp;

  logic [ACC_WIDTH-1:0] term;
  logic [ACC_WIDTH-1:0] mag;
  logic [ACC_WIDTH-1:0] mant_ext;
  int                   shift_amt;
  logic [ACC_WIDTH-1:0] sum;
  logic                 sum_ovf;
  logic [LEN_WIDTH-1:0] cnt_next;

  // Stage A alignment: value = m * 2^(e-25), placed on a 2^-FRAC_BITS grid.
  always_comb begin
    mant_ext  = {{(ACC_WIDTH-14){1'b0}}, mantissa_in};
    shift_amt = int'(exp_in) + FRAC_BITS - 25;
    mag       = '0;
    if (exp_in != 5'd0) begin
      if (shift_amt >= 0) mag = mant_ext << shift_amt;
      else                mag = mant_ext >> (-shift_amt);
    end
    term = sign_in ? (~mag + 1'b1) : mag;
  end

`ifdef FP_INT_ACC_SAT_EN
  logic [ACC_WIDTH-1:0] raw_sum;
  logic                 ovf;

  // Signed overflow: operands agree in sign but the sum does not.
  always_comb begin
    raw_sum = acc + t;
    ovf     = (acc[ACC_WIDTH-1] == t[ACC_WIDTH-1]) &&
              (raw_sum[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);
    sum     = raw_sum;
    if (ovf) sum = acc[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                    : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    sum_ovf = ovf;
  end
`else
  always_comb begin
    sum     = acc + t;
    sum_ovf = 1'b0;
  end
`endif

  assign cnt_next = cnt + LEN_WIDTH'(1);
  assign busy     = (state == ACCUM) | t_vld;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      t            <= '0;
      t_vld        <= 1'b0;
      acc          <= '0;
      cnt          <= '0;
      len_q        <= LEN_WIDTH'(1);
      sat_grp      <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      sat          <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (set) begin
        // Abort: the in-flight term and any same-cycle strobe are dropped.
        len_q   <= (len == '0) ? LEN_WIDTH'(1) : len;
        t_vld   <= 1'b0;
        state   <= IDLE;
        acc     <= '0;
        cnt     <= '0;
        sat_grp <= 1'b0;
      end else begin
        t_vld <= start_acc;
        if (start_acc) t <= term;
        if (t_vld) begin
          case (state)
            IDLE: begin
              // First term of a group seeds acc, so back-to-back groups lose no cycle.
              sat_grp <= 1'b0;
              if (len_q == LEN_WIDTH'(1)) begin
                result       <= t;
                result_valid <= 1'b1;
                sat          <= 1'b0;
                acc          <= '0;
                cnt          <= '0;
              end else begin
                acc   <= t;
                cnt   <= LEN_WIDTH'(1);
                state <= ACCUM;
              end
            end
            ACCUM: begin
              if (cnt_next == len_q) begin
                result       <= sum;
                result_valid <= 1'b1;
                sat          <= sat_grp | sum_ovf;
                acc          <= '0;
                cnt          <= '0;
                state        <= IDLE;
              end else begin
                acc     <= sum;
                cnt     <= cnt_next;
                sat_grp <= sat_grp | sum_ovf;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_int_acc.sv
// tb/tb_fp_int_acc.sv - self-checking bench for fp_int_acc

module tb_fp_int_acc;

  localparam int     FRAC = 24;
  localparam longint MAXV = (longint'(1) << 47) - 1;
  localparam longint MINV = -(longint'(1) << 47);

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        set = 1'b0;
  logic [7:0]  len = 8'd0;
  logic        start_acc = 1'b0;
  logic        sign_in = 1'b0;
  logic [4:0]  exp_in = 5'd0;
  logic [13:0] mantissa_in = 14'd0;
  logic [47:0] result;
  logic        result_valid;
  logic        busy;
  logic        sat;

  int checks = 0;
  int errors = 0;

  // Reference model state: group progress, one in-flight product, last result.
  int     m_len = 1;
  int     m_cnt = 0;
  longint m_sum = 0;
  bit     m_sat = 0;
  bit     m_if_v = 0;
  longint m_if_t = 0;
  longint m_result = 0;
  bit     m_last_sat = 0;

  fp_int_acc dut (
    .clk(clk), .rst(rst), .set(set), .len(len), .start_acc(start_acc),
    .sign_in(sign_in), .exp_in(exp_in), .mantissa_in(mantissa_in),
    .result(result), .result_valid(result_valid), .busy(busy), .sat(sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Product value in LSBs of 2^-FRAC: m * 2^(e-25) * 2^FRAC, truncated toward zero.
  function automatic longint term_value(input logic s, input logic [4:0] e, input logic [13:0] m);
    longint mag;
    int sh;
    if (e == 5'd0) return 0;
    sh = int'(e) + FRAC - 25;
    if (sh >= 0) mag = longint'(m) * (longint'(1) << sh);
    else         mag = longint'(m) / (longint'(1) << (-sh));
    return s ? -mag : mag;
  endfunction

  task automatic add_term(input longint tv);
    longint s;
    logic [63:0] w;
    s = m_sum + tv;
`ifdef FP_INT_ACC_SAT_EN
    if (s > MAXV) begin s = MAXV; m_sat = 1; end
    else if (s < MINV) begin s = MINV; m_sat = 1; end
`else
    w = s;
    w = {{16{w[47]}}, w[47:0]};
    s = w;
`endif
    m_sum = s;
  endtask

  task automatic step(input logic r_n, input logic s, input logic [7:0] l, input logic st,
                      input logic sg, input logic [4:0] e, input logic [13:0] m);
    bit ev;
    logic [63:0] rv;
    rst = r_n; set = s; len = l; start_acc = st; sign_in = sg; exp_in = e; mantissa_in = m;
    ev = 0;
    if (!r_n) begin
      m_len = 1; m_cnt = 0; m_sum = 0; m_sat = 0; m_if_v = 0; m_result = 0; m_last_sat = 0;
    end else if (s) begin
      m_len = (l == 8'd0) ? 1 : int'(l);
      m_cnt = 0; m_sum = 0; m_sat = 0; m_if_v = 0;
    end else begin
      if (m_if_v) begin
        if (m_cnt == 0) begin m_sum = m_if_t; m_sat = 0; end
        else add_term(m_if_t);
        m_cnt++;
        if (m_cnt == m_len) begin
          m_result = m_sum; m_last_sat = m_sat; ev = 1; m_cnt = 0;
        end
      end
      m_if_v = st;
      m_if_t = term_value(sg, e, m);
    end
    @(posedge clk);
    #1;
    rv = m_result;
    check("result_valid", result_valid, ev);
    check("result", result, rv[47:0]);
    check("busy", busy, (m_cnt != 0) || m_if_v);
    if (ev || !r_n) check("sat", sat, m_last_sat);
  endtask

  task automatic do_set(input logic [7:0] l);
    step(1, 1, l, 0, 0, 5'd0, 14'd0);
  endtask

  task automatic strobe(input logic sg, input logic [4:0] e, input logic [13:0] m);
    step(1, 0, 8'd0, 1, sg, e, m);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 8'd0, 0, 0, 5'd0, 14'd0);
  endtask

  initial begin
    // Reset state
    step(0, 0, 8'd0, 0, 0, 5'd0, 14'd0);
    step(0, 0, 8'd0, 1, 0, 5'd15, 14'h0400);

    // len 1, single +1.0: pulse only two cycles after the strobe
    do_set(8'd1);
    strobe(0, 5'd15, 14'h0400);
    idle(3);
    check("len1_result", result, 48'h000001000000);

    // len 3: +1 -1 +2
    do_set(8'd3);
    strobe(0, 5'd15, 14'h0400);
    strobe(1, 5'd15, 14'h0400);
    strobe(0, 5'd16, 14'h0400);
    idle(3);
    check("len3_result", result, 48'h000002000000);

    // Zero-exponent product and smallest aligned term
    do_set(8'd2);
    strobe(0, 5'd0, 14'h3FFF);
    strobe(0, 5'd1, 14'h0001);
    idle(3);
    check("exp0_result", result, 48'h000000000001);

    // Back-to-back groups
    do_set(8'd2);
    for (int i = 0; i < 4; i++) strobe(0, 5'd15, 14'h0400);
    idle(3);
    check("b2b_result", result, 48'h000002000000);

    // Overflow
    do_set(8'd9);
    for (int i = 0; i < 9; i++) strobe(0, 5'd31, 14'h3FFF);
    idle(3);
`ifdef FP_INT_ACC_SAT_EN
    check("ovf_result", result, 48'h7FFFFFFFFFFF);
    check("ovf_sat", sat, 1'b1);
`else
    check("ovf_result", result, 48'h8FFDC0000000);
    check("ovf_sat", sat, 1'b0);
`endif

    // Reset with a term in flight
    do_set(8'd2);
    strobe(0, 5'd15, 14'h0400);
    step(0, 0, 8'd0, 0, 0, 5'd0, 14'd0);
    do_set(8'd1);
    strobe(0, 5'd16, 14'h0400);
    idle(3);
    check("rst_result", result, 48'h000002000000);

    // Randomized traffic with aborts, resets and set-cycle strobes
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2)
        step(0, 0, 8'd0, 1'($urandom), 0, 5'd0, 14'd0);
      else if (r < 7)
        step(1, 1, 8'($urandom_range(0, 5)), 1'($urandom), 1'($urandom),
             5'($urandom), 14'($urandom));
      else
        step(1, 0, 8'($urandom), ($urandom_range(0, 9) < 7), 1'($urandom),
             5'($urandom), 14'($urandom));
    end
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
